// File: rtl/conv_channel_adder_param_if.sv
// conv_channel_adder_param_if: stream bus for the channel adder stage
// Ports (master drives / slave receives):
//   relu_en, bias_valid, bias_in, valid_in, pxl_in      master -> slave
//   pxl_out, valid_out, channel_done, layer_done        slave -> master
interface conv_channel_adder_param_if #(
   parameter int DATA_WIDTH = 16
);
   logic                         relu_en;
   logic                         bias_valid;
   logic signed [DATA_WIDTH-1:0] bias_in;
   logic                         valid_in;
   logic signed [DATA_WIDTH-1:0] pxl_in;
   logic signed [DATA_WIDTH-1:0] pxl_out;
   logic                         valid_out;
   logic                         channel_done;
   logic                         layer_done;
   modport master (
      output relu_en, bias_valid, bias_in, valid_in, pxl_in,
      input  pxl_out, valid_out, channel_done, layer_done
   );
   modport slave (
      input  relu_en, bias_valid, bias_in, valid_in, pxl_in,
      output pxl_out, valid_out, channel_done, layer_done
   );
endinterface

// File: rtl/conv_channel_adder_param.sv
// conv_channel_adder_param: sums per-input-channel partial images, adds bias, optional ReLU, saturates
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of conv_channel_adder_param_if (pixel stream in, result stream out)
module conv_channel_adder_param #(
   parameter int DATA_WIDTH      = 16,
   parameter int IMAGE_WIDTH     = 32,
   parameter int IMAGE_HEIGHT    = 32,
   parameter int IMAGE_SIZE      = IMAGE_WIDTH * IMAGE_HEIGHT,
   parameter int CHANNEL_NUM_IN  = 1024,
   parameter int CHANNEL_NUM_OUT = 256,
   parameter int ACC_WIDTH       = DATA_WIDTH + $clog2(CHANNEL_NUM_IN)
) (
   input logic clk,
   input logic reset,
   conv_channel_adder_param_if.slave bus
);
   localparam int PW = IMAGE_SIZE > 1 ? $clog2(IMAGE_SIZE) : 1;
   localparam int IW = CHANNEL_NUM_IN > 1 ? $clog2(CHANNEL_NUM_IN) : 1;
   localparam int OW = CHANNEL_NUM_OUT > 1 ? $clog2(CHANNEL_NUM_OUT) : 1;
   localparam int SW = ACC_WIDTH + 1;
   localparam logic signed [DATA_WIDTH-1:0] PMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] PMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [PW-1:0] pix_cnt, s1_addr;
   logic [IW-1:0] ich_cnt;
   logic [OW-1:0] och_cnt;
   logic pix_first, pix_last, ich_first, ich_last, och_last;
   logic signed [DATA_WIDTH-1:0] bias_reg, bias_active, s1_pxl, sat, res;
   logic s1_valid, s1_first, s1_last, s1_pix_last, s1_och_last, s1_relu, fire;
   logic signed [ACC_WIDTH-1:0] ram [IMAGE_SIZE];
   logic signed [ACC_WIDTH-1:0] rd;
   logic signed [SW-1:0] sum;

   assign pix_first = pix_cnt == '0;
   assign pix_last  = pix_cnt == PW'(IMAGE_SIZE - 1);
   assign ich_first = ich_cnt == '0;
   assign ich_last  = ich_cnt == IW'(CHANNEL_NUM_IN - 1);
   assign och_last  = och_cnt == OW'(CHANNEL_NUM_OUT - 1);
   assign fire      = s1_valid && s1_last;

   // Final-channel result: on the first input channel the stale RAM word is ignored,
   // which also covers the single-input-channel configuration.
   always_comb begin
      sum = (s1_first ? SW'(0) : SW'(rd)) + SW'(s1_pxl) + SW'(bias_active);
      sat = sum > SW'(PMAX) ? PMAX : sum < SW'(PMIN) ? PMIN : sum[DATA_WIDTH-1:0];
      res = s1_relu && sat[DATA_WIDTH-1] ? '0 : sat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_cnt          <= '0;
         ich_cnt          <= '0;
         och_cnt          <= '0;
         bias_reg         <= '0;
         bias_active      <= '0;
         s1_valid         <= 1'b0;
         bus.pxl_out      <= '0;
         bus.valid_out    <= 1'b0;
         bus.channel_done <= 1'b0;
         bus.layer_done   <= 1'b0;
      end else begin
         if (bus.bias_valid) bias_reg <= bus.bias_in;
         s1_valid <= bus.valid_in;
         if (bus.valid_in) begin
            pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
            if (pix_last) ich_cnt <= ich_last ? '0 : ich_cnt + 1'b1;
            if (pix_last && ich_last) och_cnt <= och_last ? '0 : och_cnt + 1'b1;
            // A bias written in the same cycle as the channel's first pixel takes effect immediately.
            if (pix_first && ich_first) bias_active <= bus.bias_valid ? bus.bias_in : bias_reg;
         end
         bus.valid_out    <= fire;
         bus.channel_done <= fire && s1_pix_last;
         bus.layer_done   <= fire && s1_pix_last && s1_och_last;
         if (fire) bus.pxl_out <= res;
      end
   end

   // Stage-1 data and the accumulator RAM carry no reset; s1_valid gates every use.
   // A write-back lands one cycle after its read and the address recurs only
   // IMAGE_SIZE >= 4 accepted pixels later, so no bypass is required.
   always_ff @(posedge clk) begin
      if (bus.valid_in) begin
         s1_pxl      <= bus.pxl_in;
         s1_addr     <= pix_cnt;
         s1_first    <= ich_first;
         s1_last     <= ich_last;
         s1_pix_last <= pix_last;
         s1_och_last <= och_last;
         s1_relu     <= bus.relu_en;
         rd          <= ram[pix_cnt];
      end
      if (s1_valid && !s1_last) ram[s1_addr] <= s1_first ? ACC_WIDTH'(s1_pxl) : rd + ACC_WIDTH'(s1_pxl);
   end
endmodule
